// File: rtl/sram_march_tester.sv
// SRAM test sequencer: March C-, write sweep and read sweep over an external
// single-port macro, with on-the-fly read checking one cycle after each read.
module sram_march_tester #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 2,
  parameter int ERR_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [DATA_WIDTH-1:0]  pattern,
  input  logic [WMASK_WIDTH-1:0] wmask_cfg,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_WIDTH-1:0]   error_count,
  output logic [ADDR_WIDTH-1:0]  first_fail_addr,
  output logic                   mem_we,
  output logic [WMASK_WIDTH-1:0] mem_wmask,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_din,
  input  logic [DATA_WIDTH-1:0]  mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;
  typedef enum logic [1:0] {M_MARCH, M_WSWEEP, M_RSWEEP} mode_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0]  ERR_ONE  = ERR_WIDTH'(1);

  state_e                 state_q;
  mode_e                  mode_q;
  logic [DATA_WIDTH-1:0]  pat_q;
  logic [WMASK_WIDTH-1:0] wmcfg_q;
  logic [2:0]             elem_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   wph_q;
  logic                   busy_q, done_q, pass_q;
  logic [ERR_WIDTH-1:0]   err_q, err_d;
  logic [ADDR_WIDTH-1:0]  ffa_q, ffa_d;
  logic                   mem_we_q;
  logic [WMASK_WIDTH-1:0] mem_wmask_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [DATA_WIDTH-1:0]  mem_din_q;
  logic                   op_rd_q;
  logic [DATA_WIDTH-1:0]  op_exp_q;
  logic                   chk_vld_q;
  logic [DATA_WIDTH-1:0]  chk_exp_q;
  logic [ADDR_WIDTH-1:0]  chk_addr_q;

  logic                   accept, last_op, asc, at_term, mismatch;
  mode_e                  sel_mode;
  logic [DATA_WIDTH-1:0]  sel_pat, d0, d1, sweep_word;
  logic [WMASK_WIDTH-1:0] sel_wm;
  logic [2:0]             adv_elem, nxt_elem;
  logic [ADDR_WIDTH-1:0]  adv_addr, nxt_addr;
  logic                   adv_wph, nxt_wph;
  logic                   gen_we, gen_rd;
  logic [WMASK_WIDTH-1:0] gen_wmask;
  logic [DATA_WIDTH-1:0]  gen_din, gen_exp;

  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  // The cursor (elem/addr/wph) names the operation currently on the bus;
  // this block finds the operation that follows it.
  always_comb begin
    adv_elem = elem_q;
    adv_addr = addr_q;
    adv_wph  = wph_q;
    last_op  = 1'b0;
    asc      = !(elem_q == 3'd3 || elem_q == 3'd4);
    at_term  = asc ? (addr_q == ADDR_MAX) : (addr_q == '0);
    if (mode_q == M_MARCH) begin
      if (elem_q != 3'd0 && elem_q != 3'd5 && !wph_q) begin
        adv_wph = 1'b1;
      end else if (at_term) begin
        if (elem_q == 3'd5) begin
          last_op = 1'b1;
        end else begin
          adv_elem = elem_q + 3'd1;
          adv_wph  = 1'b0;
          adv_addr = (adv_elem == 3'd3 || adv_elem == 3'd4) ? ADDR_MAX : '0;
        end
      end else begin
        adv_addr = asc ? addr_q + ADDR_ONE : addr_q - ADDR_ONE;
        adv_wph  = (elem_q == 3'd0);
      end
    end else begin
      last_op  = (addr_q == ADDR_MAX);
      adv_addr = addr_q + ADDR_ONE;
    end
  end

  // On accept the first operation is built from the live inputs, since the
  // configuration registers are only loaded at that same edge.
  always_comb begin
    case (mode)
      2'd1:    sel_mode = M_WSWEEP;
      2'd2:    sel_mode = M_RSWEEP;
      default: sel_mode = M_MARCH;
    endcase
    if (!accept) sel_mode = mode_q;
    sel_pat = accept ? pattern : pat_q;
    sel_wm  = accept ? wmask_cfg : wmcfg_q;
    if (accept) begin
      nxt_elem = 3'd0;
      nxt_addr = '0;
      nxt_wph  = (sel_mode != M_RSWEEP);
    end else begin
      nxt_elem = adv_elem;
      nxt_addr = adv_addr;
      nxt_wph  = adv_wph;
    end
    d0         = sel_pat;
    d1         = ~sel_pat;
    sweep_word = nxt_addr[0] ? d1 : d0;
    gen_we     = 1'b0;
    gen_rd     = 1'b0;
    gen_wmask  = '0;
    gen_din    = '0;
    gen_exp    = '0;
    case (sel_mode)
      M_MARCH: begin
        gen_wmask = '1;
        if (nxt_wph) begin
          gen_we  = 1'b1;
          gen_din = nxt_elem[0] ? d1 : d0;
        end else begin
          gen_rd  = 1'b1;
          gen_exp = nxt_elem[0] ? d0 : d1;
        end
      end
      M_WSWEEP: begin
        gen_we    = 1'b1;
        gen_wmask = sel_wm;
        gen_din   = sweep_word;
      end
      default: begin
        gen_rd  = 1'b1;
        gen_exp = sweep_word;
      end
    endcase
  end

  always_comb begin
    mismatch = chk_vld_q && (mem_dout != chk_exp_q);
    err_d    = err_q;
    ffa_d    = ffa_q;
    if (mismatch) begin
      if (err_q == '0) ffa_d = chk_addr_q;
      if (err_q != '1) err_d = err_q + ERR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= M_MARCH;
      pat_q       <= '0;
      wmcfg_q     <= '0;
      elem_q      <= '0;
      addr_q      <= '0;
      wph_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ffa_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_wmask_q <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      op_rd_q     <= 1'b0;
      op_exp_q    <= '0;
      chk_vld_q   <= 1'b0;
      chk_exp_q   <= '0;
      chk_addr_q  <= '0;
    end else begin
      err_q      <= err_d;
      ffa_q      <= ffa_d;
      chk_vld_q  <= op_rd_q;
      chk_exp_q  <= op_exp_q;
      chk_addr_q <= mem_addr_q;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_q     <= S_RUN;
            mode_q      <= sel_mode;
            pat_q       <= pattern;
            wmcfg_q     <= wmask_cfg;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            ffa_q       <= '0;
            elem_q      <= nxt_elem;
            addr_q      <= nxt_addr;
            wph_q       <= nxt_wph;
            mem_we_q    <= gen_we;
            mem_wmask_q <= gen_wmask;
            mem_addr_q  <= nxt_addr;
            mem_din_q   <= gen_din;
            op_rd_q     <= gen_rd;
            op_exp_q    <= gen_exp;
          end
        end
        S_RUN: begin
          if (last_op) begin
            state_q     <= S_FLUSH;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            op_rd_q     <= 1'b0;
            op_exp_q    <= '0;
          end else begin
            elem_q      <= nxt_elem;
            addr_q      <= nxt_addr;
            wph_q       <= nxt_wph;
            mem_we_q    <= gen_we;
            mem_wmask_q <= gen_wmask;
            mem_addr_q  <= nxt_addr;
            mem_din_q   <= gen_din;
            op_rd_q     <= gen_rd;
            op_exp_q    <= gen_exp;
          end
        end
        default: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_d == '0);
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_count     = err_q;
  assign first_fail_addr = ffa_q;
  assign mem_we          = mem_we_q;
  assign mem_wmask       = mem_wmask_q;
  assign mem_addr        = mem_addr_q;
  assign mem_din         = mem_din_q;

endmodule

// File: tb/tb_sram_march_tester.sv
// Directed bench: 64x4 masked macro model (optional stuck-at bit) plus a
// second tester instance with a 4-bit error counter facing an all-zero macro.
module tb_sram_march_tester;
  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [3:0] pattern;
  logic [1:0] wmask_cfg;
  logic       busy, done, pass;
  logic [15:0] error_count;
  logic [5:0] first_fail_addr;
  logic       mem_we;
  logic [1:0] mem_wmask;
  logic [5:0] mem_addr;
  logic [3:0] mem_din;
  logic [3:0] mem_dout;

  logic       start4;
  logic [1:0] mode4;
  logic [3:0] pattern4;
  logic [1:0] wmask4;
  logic       busy4, done4, pass4;
  logic [3:0] err4;
  logic [5:0] ffa4;
  logic       we4;
  logic [1:0] wm4;
  logic [5:0] addr4;
  logic [3:0] din4;
  logic [3:0] dout4;

  logic [3:0] mem [0:63];
  logic [3:0] wword;
  logic       fault_en;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  always #5 clock = ~clock;

  sram_march_tester #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WMASK_WIDTH(2), .ERR_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .pattern(pattern),
    .wmask_cfg(wmask_cfg), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_fail_addr(first_fail_addr),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout));

  sram_march_tester #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WMASK_WIDTH(2), .ERR_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .mode(mode4), .pattern(pattern4),
    .wmask_cfg(wmask4), .busy(busy4), .done(done4), .pass(pass4),
    .error_count(err4), .first_fail_addr(ffa4),
    .mem_we(we4), .mem_wmask(wm4), .mem_addr(addr4),
    .mem_din(din4), .mem_dout(dout4));

  assign dout4 = 4'h0;

  // Macro model: masked write, registered read; optional bit0 stuck-at-0 at addr 5.
  always @(posedge clock) begin
    if (mem_we) begin
      wword = mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b/2]) wword[b] = mem_din[b];
      mem[mem_addr] <= wword;
    end else begin
      mem_dout <= mem[mem_addr] & ((fault_en && mem_addr == 6'd5) ? 4'hE : 4'hF);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic start_run(input logic [1:0] m, input logic [3:0] p, input logic [1:0] wm);
    start = 1'b1; mode = m; pattern = p; wmask_cfg = wm;
    tick();
    cyc = 1;
    start = 1'b0; mode = m ^ 2'b01; pattern = ~p; wmask_cfg = ~wm;
  endtask

  task automatic wait_done(output int dc);
    while (!done && cyc < 3000) tick();
    dc = cyc;
  endtask

  task automatic test_reset();
    int dc;
    reset = 1'b1; start = 1'b0; start4 = 1'b0;
    mode = 2'd0; pattern = 4'h0; wmask_cfg = 2'b00;
    mode4 = 2'd0; pattern4 = 4'h0; wmask4 = 2'b00;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", pass); end
    checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", error_count); end
    checks++; if (first_fail_addr !== 6'd0) begin errors++; $display("FAIL reset_ffa got=%0d exp=0", first_fail_addr); end
    checks++; if ({mem_we, mem_wmask, mem_addr, mem_din} !== 13'd0) begin
      errors++; $display("FAIL reset_mem got=%h exp=0", {mem_we, mem_wmask, mem_addr, mem_din}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_march_clean();
    int dc;
    fault_en = 1'b0;
    start_run(2'd0, 4'h0, 2'b00);
    checks++; if ({busy, mem_we, mem_wmask, mem_addr, mem_din} !== {1'b1, 1'b1, 2'b11, 6'd0, 4'h0}) begin
      errors++; $display("FAIL march_first_op got=%b/%b/%b/%0d/%h exp=1/1/11/0/0",
                         busy, mem_we, mem_wmask, mem_addr, mem_din); end
    go_to(65);
    checks++; if ({mem_we, mem_addr} !== {1'b0, 6'd0}) begin
      errors++; $display("FAIL march_e1_read got we=%b addr=%0d exp we=0 addr=0", mem_we, mem_addr); end
    tick();
    checks++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 6'd0, 4'hF}) begin
      errors++; $display("FAIL march_e1_write got we=%b addr=%0d din=%h exp 1/0/F", mem_we, mem_addr, mem_din); end
    go_to(321);
    checks++; if ({mem_we, mem_addr} !== {1'b0, 6'd63}) begin
      errors++; $display("FAIL march_e3_start got we=%b addr=%0d exp we=0 addr=63", mem_we, mem_addr); end
    go_to(640);
    checks++; if ({mem_we, mem_addr, done} !== {1'b0, 6'd63, 1'b0}) begin
      errors++; $display("FAIL march_last_op got we=%b addr=%0d done=%b exp 0/63/0", mem_we, mem_addr, done); end
    wait_done(dc);
    checks++; if (dc !== 642) begin errors++; $display("FAIL march_done_cycle got=%0d exp=642", dc); end
    checks++; if ({pass, busy, error_count, first_fail_addr} !== {1'b1, 1'b0, 16'd0, 6'd0}) begin
      errors++; $display("FAIL march_clean_result got pass=%b busy=%b err=%0d ffa=%0d exp 1/0/0/0",
                         pass, busy, error_count, first_fail_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL done_mem_we got=%b exp=0", mem_we); end
  endtask

  task automatic test_march_fault();
    int dc;
    fault_en = 1'b1;
    start_run(2'd0, 4'h0, 2'b00);
    wait_done(dc);
    checks++; if (dc !== 642) begin errors++; $display("FAIL fault_done_cycle got=%0d exp=642", dc); end
    checks++; if (error_count !== 16'd2) begin errors++; $display("FAIL fault_err got=%0d exp=2", error_count); end
    checks++; if (first_fail_addr !== 6'd5) begin errors++; $display("FAIL fault_ffa got=%0d exp=5", first_fail_addr); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL fault_pass got=%b exp=0", pass); end
    fault_en = 1'b0;
  endtask

  task automatic test_sweeps();
    int dc;
    start_run(2'd1, 4'hA, 2'b11);
    checks++; if ({mem_we, mem_wmask, mem_addr, mem_din} !== {1'b1, 2'b11, 6'd0, 4'hA}) begin
      errors++; $display("FAIL wsweep_op0 got %b/%b/%0d/%h exp 1/11/0/A", mem_we, mem_wmask, mem_addr, mem_din); end
    tick();
    checks++; if ({mem_addr, mem_din} !== {6'd1, 4'h5}) begin
      errors++; $display("FAIL wsweep_op1 got addr=%0d din=%h exp 1/5", mem_addr, mem_din); end
    wait_done(dc);
    checks++; if (dc !== 66) begin errors++; $display("FAIL wsweep_done_cycle got=%0d exp=66", dc); end
    start_run(2'd2, 4'hA, 2'b00);
    wait_done(dc);
    checks++; if (dc !== 66) begin errors++; $display("FAIL rsweep_done_cycle got=%0d exp=66", dc); end
    checks++; if ({error_count, pass} !== {16'd0, 1'b1}) begin
      errors++; $display("FAIL rsweep_clean got err=%0d pass=%b exp 0/1", error_count, pass); end
    start_run(2'd1, 4'h5, 2'b01);
    checks++; if (mem_wmask !== 2'b01) begin errors++; $display("FAIL wsweep_mask got=%b exp=01", mem_wmask); end
    wait_done(dc);
    start_run(2'd2, 4'h5, 2'b00);
    wait_done(dc);
    checks++; if ({error_count, first_fail_addr, pass} !== {16'd64, 6'd0, 1'b0}) begin
      errors++; $display("FAIL rsweep_masked got err=%0d ffa=%0d pass=%b exp 64/0/0",
                         error_count, first_fail_addr, pass); end
  endtask

  task automatic test_reset_midrun();
    int dc;
    fault_en = 1'b1;
    start_run(2'd0, 4'h0, 2'b00);
    go_to(300);
    checks++; if ({mem_we, mem_addr, error_count, first_fail_addr} !== {1'b1, 6'd53, 16'd1, 6'd5}) begin
      errors++; $display("FAIL midrun_state got we=%b addr=%0d err=%0d ffa=%0d exp 1/53/1/5",
                         mem_we, mem_addr, error_count, first_fail_addr); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fault_en = 1'b0;
    checks++; if ({busy, done, mem_we, error_count, first_fail_addr} !== 25'd0) begin
      errors++; $display("FAIL midrun_reset got busy=%b done=%b we=%b err=%0d ffa=%0d exp all 0",
                         busy, done, mem_we, error_count, first_fail_addr); end
    start_run(2'd0, 4'h3, 2'b00);
    wait_done(dc);
    checks++; if ({dc == 642, pass, error_count} !== {1'b1, 1'b1, 16'd0}) begin
      errors++; $display("FAIL after_reset_run got cycle=%0d pass=%b err=%0d exp 642/1/0", dc, pass, error_count); end
  endtask

  task automatic test_back_to_back();
    int dc;
    start_run(2'd3, 4'h9, 2'b00);
    go_to(10);
    start = 1'b1; mode = 2'd1; pattern = 4'h0;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignored_start_busy got=%b exp=1", busy); end
    wait_done(dc);
    checks++; if (dc !== 642) begin errors++; $display("FAIL ignored_start_done got=%0d exp=642", dc); end
    checks++; if ({pass, error_count} !== {1'b1, 16'd0}) begin
      errors++; $display("FAIL ignored_start_result got pass=%b err=%0d exp 1/0", pass, error_count); end
  endtask

  task automatic test_saturate();
    int n;
    start4 = 1'b1; mode4 = 2'd2; pattern4 = 4'hF;
    tick();
    start4 = 1'b0;
    n = 1;
    while (!done4 && n < 500) begin tick(); n++; end
    checks++; if (n !== 66) begin errors++; $display("FAIL sat_done_cycle got=%0d exp=66", n); end
    checks++; if ({err4, ffa4, pass4} !== {4'hF, 6'd0, 1'b0}) begin
      errors++; $display("FAIL sat_result got err=%h ffa=%0d pass=%b exp F/0/0", err4, ffa4, pass4); end
  endtask

  initial begin
    fault_en = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 4'h0;
    test_reset();
    test_march_clean();
    test_march_fault();
    test_sweeps();
    test_reset_midrun();
    test_back_to_back();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
